// File: rtl/ks_16b_arbiter.sv
// Two-requester round-robin front end sharing one 16-bit Kogge-Stone adder.
// The result is registered with a valid/ready output and per-requester delivery counters.

module ks_16b (
    input  logic [15:0] in0,
    input  logic [15:0] in1,
    output logic [16:0] out0
);
    logic [15:0] x;
    logic [15:0] g0, g1, g2, g3, g4;
    logic [15:0] p0, p1, p2, p3;

    assign x  = in0 ^ in1;
    assign g0 = in0 & in1;
    assign p0 = x;

    // Prefix levels with spans 1, 2, 4, 8; shifted-in propagate bits are identity.
    assign g1 = g0 | (p0 & {g0[14:0], 1'b0});
    assign p1 = p0 & {p0[14:0], 1'b1};
    assign g2 = g1 | (p1 & {g1[13:0], 2'b0});
    assign p2 = p1 & {p1[13:0], 2'b11};
    assign g3 = g2 | (p2 & {g2[11:0], 4'b0});
    assign p3 = p2 & {p2[11:0], 4'hf};
    assign g4 = g3 | (p3 & {g3[7:0], 8'b0});

    assign out0 = {g4[15], x ^ {g4[14:0], 1'b0}};
endmodule

module ks_16b_arbiter #(
    parameter int RR_INIT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [15:0] req0_a,
    input  logic [15:0] req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [15:0] req1_a,
    input  logic [15:0] req1_b,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [16:0] res_sum,
    output logic        res_id,
    output logic [15:0] cnt0,
    output logic [15:0] cnt1
);
    localparam logic PTR_RST = (RR_INIT == 0);

    logic        last;
    logic        grant0;
    logic        grant1;
    logic        can_accept;
    logic        fire;
    logic [15:0] sel_a;
    logic [15:0] sel_b;
    logic [16:0] sum;

    // On contention the requester that did not win last time goes first.
    assign grant0 = req0_valid & (~req1_valid | last);
    assign grant1 = req1_valid & (~req0_valid | ~last);

    assign can_accept = ~res_valid | res_ready;
    assign req0_ready = grant0 & can_accept & ~rst;
    assign req1_ready = grant1 & can_accept & ~rst;
    assign fire       = req0_ready | req1_ready;

    assign sel_a = grant1 ? req1_a : req0_a;
    assign sel_b = grant1 ? req1_b : req0_b;

    ks_16b u_add (
        .in0  (sel_a),
        .in1  (sel_b),
        .out0 (sum)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid <= 1'b0;
            res_sum   <= '0;
            res_id    <= 1'b0;
            cnt0      <= '0;
            cnt1      <= '0;
            last      <= PTR_RST;
        end else begin
            if (res_valid && res_ready) begin
                if (res_id) cnt1 <= cnt1 + 16'd1;
                else        cnt0 <= cnt0 + 16'd1;
            end
            if (fire) begin
                res_valid <= 1'b1;
                res_sum   <= sum;
                res_id    <= req1_ready;
                last      <= req1_ready;
            end else if (res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_ks_16b_arbiter.sv
// Scoreboard bench for ks_16b_arbiter: directed scenarios plus randomized traffic
// checked against a behavioural arbitration/sum model.

module tb_ks_16b_arbiter;
    localparam int RR_INIT = 0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 1'b0;
    logic        req0_ready;
    logic [15:0] req0_a = '0;
    logic [15:0] req0_b = '0;
    logic        req1_valid = 1'b0;
    logic        req1_ready;
    logic [15:0] req1_a = '0;
    logic [15:0] req1_b = '0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [16:0] res_sum;
    logic        res_id;
    logic [15:0] cnt0;
    logic [15:0] cnt1;

    int checks = 0;
    int errors = 0;

    ks_16b_arbiter #(.RR_INIT(RR_INIT)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_sum    (res_sum),
        .res_id     (res_id),
        .cnt0       (cnt0),
        .cnt1       (cnt1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Expected deliveries: {id, sum}
    logic [17:0] sb[$];

    // Issue-side model: arbitration, result register contents, pointer
    int          m_last;
    bit          m_pending;
    logic [16:0] m_sum;
    logic        m_id;
    bit          m_can;
    int          m_g;
    logic [16:0] m_s;

    always @(negedge clk) begin
        if (rst) begin
            chk("ready0_in_reset", {31'b0, req0_ready}, 32'd0);
            chk("ready1_in_reset", {31'b0, req1_ready}, 32'd0);
            m_last    = 1 - RR_INIT;
            m_pending = 0;
            m_sum     = '0;
            m_id      = 1'b0;
        end else begin
            chk("res_valid", {31'b0, res_valid}, {31'b0, m_pending});
            chk("res_sum_reg", {15'b0, res_sum}, {15'b0, m_sum});
            chk("res_id_reg", {31'b0, res_id}, {31'b0, m_id});
            m_can = !m_pending || res_ready;
            if (req0_valid && req1_valid) m_g = 1 - m_last;
            else if (req0_valid)          m_g = 0;
            else if (req1_valid)          m_g = 1;
            else                          m_g = -1;
            if (!m_can) m_g = -1;
            chk("req0_ready", {31'b0, req0_ready}, (m_g == 0) ? 32'd1 : 32'd0);
            chk("req1_ready", {31'b0, req1_ready}, (m_g == 1) ? 32'd1 : 32'd0);
            if (m_g >= 0) begin
                if (m_g == 0) m_s = 17'(req0_a) + 17'(req0_b);
                else          m_s = 17'(req1_a) + 17'(req1_b);
                sb.push_back({m_g[0], m_s});
                m_pending = 1;
                m_sum     = m_s;
                m_id      = m_g[0];
                m_last    = m_g;
            end else if (res_ready) begin
                m_pending = 0;
            end
        end
    end

    // Delivery monitor: pops the scoreboard and tracks delivery counts
    logic [15:0] e_cnt0;
    logic [15:0] e_cnt1;
    logic [17:0] e_item;

    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            e_cnt0 = '0;
            e_cnt1 = '0;
        end else begin
            chk("cnt0", {16'b0, cnt0}, {16'b0, e_cnt0});
            chk("cnt1", {16'b0, cnt1}, {16'b0, e_cnt1});
            if (res_valid && res_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL deliver: got result 0x%0h with no pending expectation", res_sum);
                end else begin
                    e_item = sb.pop_front();
                    chk("deliver_sum", {15'b0, res_sum}, {15'b0, e_item[16:0]});
                    chk("deliver_id", {31'b0, res_id}, {31'b0, e_item[17]});
                    if (e_item[17]) e_cnt1 = e_cnt1 + 16'd1;
                    else            e_cnt0 = e_cnt0 + 16'd1;
                end
            end
        end
    end

    task automatic drive(input logic v0, input logic [15:0] a0, input logic [15:0] b0,
                         input logic v1, input logic [15:0] a1, input logic [15:0] b1,
                         input logic rr);
        @(posedge clk);
        #1;
        req0_valid = v0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_a = a1; req1_b = b1;
        res_ready  = rr;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        res_ready  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic last_id;

        // V1
        do_reset();
        settle();
        chk("v1_reset_valid", {31'b0, res_valid}, 32'd0);
        chk("v1_reset_sum", {15'b0, res_sum}, 32'd0);
        drive(1, 16'h1234, 16'h0001, 0, 16'h0, 16'h0, 1);
        settle();
        chk("v1_ready0", {31'b0, req0_ready}, 32'd1);
        drive(0, 16'h0, 16'h0, 0, 16'h0, 16'h0, 1);
        settle();
        chk("v1_valid", {31'b0, res_valid}, 32'd1);
        chk("v1_sum", {15'b0, res_sum}, 32'h01235);
        chk("v1_id", {31'b0, res_id}, 32'd0);
        drive(0, 16'h0, 16'h0, 0, 16'h0, 16'h0, 1);
        settle();
        chk("v1_cnt0", {16'b0, cnt0}, 32'd1);

        // V2: alternating grants under continuous contention
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive(1, 16'($urandom), 16'($urandom), 1, 16'($urandom), 16'($urandom), 1);
            settle();
            chk("v2_ready0", {31'b0, req0_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("v2_ready1", {31'b0, req1_ready}, (i % 2 == 1) ? 32'd1 : 32'd0);
        end

        // V3: full-scale operands
        drive(0, 16'h0, 16'h0, 1, 16'hffff, 16'hffff, 1);
        drive(0, 16'h0, 16'h0, 0, 16'h0, 16'h0, 1);
        settle();
        chk("v3_sum", {15'b0, res_sum}, 32'h1fffe);
        chk("v3_id", {31'b0, res_id}, 32'd1);

        // V4: stalled result under contention, then release
        do_reset();
        drive(1, 16'h00aa, 16'h0055, 0, 16'h0, 16'h0, 0);
        last_id = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1, 16'h1111, 16'h2222, 1, 16'h3333, 16'h4444, 0);
            settle();
            chk("v4_ready0_stall", {31'b0, req0_ready}, 32'd0);
            chk("v4_ready1_stall", {31'b0, req1_ready}, 32'd0);
            chk("v4_sum_hold", {15'b0, res_sum}, 32'h000ff);
        end
        drive(1, 16'h1111, 16'h2222, 1, 16'h3333, 16'h4444, 1);
        settle();
        chk("v4_release_ready1", {31'b0, req1_ready}, {31'b0, ~last_id});
        chk("v4_release_ready0", {31'b0, req0_ready}, {31'b0, last_id});

        // V5: reset discards a pending result
        do_reset();
        drive(1, 16'h0f0f, 16'h0101, 0, 16'h0, 16'h0, 0);
        drive(0, 16'h0, 16'h0, 0, 16'h0, 16'h0, 0);
        settle();
        chk("v5_pending", {31'b0, res_valid}, 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        res_ready = 1'b0;
        settle();
        chk("v5_valid", {31'b0, res_valid}, 32'd0);
        chk("v5_sum", {15'b0, res_sum}, 32'd0);
        chk("v5_cnt0", {16'b0, cnt0}, 32'd0);
        chk("v5_cnt1", {16'b0, cnt1}, 32'd0);

        // V6: 65536 deliveries from requester 0 wrap the counter
        do_reset();
        for (int i = 0; i < 65536; i++)
            drive(1, 16'(i), 16'h0003, 0, 16'h0, 16'h0, 1);
        drive(0, 16'h0, 16'h0, 0, 16'h0, 16'h0, 1);
        drive(0, 16'h0, 16'h0, 0, 16'h0, 16'h0, 1);
        settle();
        chk("v6_cnt0_wrap", {16'b0, cnt0}, 32'd0);
        chk("v6_cnt1", {16'b0, cnt1}, 32'd0);

        // V7: randomized traffic and backpressure
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            logic [15:0] a0, b0, a1, b1;
            a0 = ($urandom_range(0, 7) == 0) ? 16'hffff : 16'($urandom);
            b0 = 16'($urandom);
            a1 = 16'($urandom);
            b1 = ($urandom_range(0, 7) == 0) ? 16'hffff : 16'($urandom);
            drive(1'($urandom_range(0, 1)), a0, b0,
                  1'($urandom_range(0, 1)), a1, b1,
                  ($urandom_range(0, 9) < 7));
        end
        drive(0, 16'h0, 16'h0, 0, 16'h0, 16'h0, 1);
        repeat (3) drive(0, 16'h0, 16'h0, 0, 16'h0, 16'h0, 1);
        settle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ks_16b_arbiter.md
KS_16B_ARBITER -- requirements
Module: ks_16b_arbiter

Interface
REQ-001 Parameter RR_INIT, default 0, SHALL select which requester (0 or 1) holds priority after reset.
REQ-002 Port clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst  input  1  SHALL be the synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 Port req0_valid  input  1  SHALL indicate that requester 0 operands are valid.
REQ-005 Port req0_ready  output  1  SHALL indicate that requester 0 operands are accepted this cycle.
REQ-006 Port req0_a  input  16  SHALL carry requester 0 operand A.
REQ-007 Port req0_b  input  16  SHALL carry requester 0 operand B.
REQ-008 Ports req1_valid, req1_ready, req1_a, req1_b SHALL mirror REQ-004..REQ-007 for requester 1.
REQ-009 Port res_valid  output  1  SHALL indicate that the result register holds an undelivered result.
REQ-010 Port res_ready  input  1  SHALL indicate that the consumer accepts the result this cycle.
REQ-011 Port res_sum  output  17  SHALL carry the registered sum, with the carry-out in bit 16.
REQ-012 Port res_id  output  1  SHALL identify the requester that produced res_sum.
REQ-013 Ports cnt0, cnt1  output  16 each  SHALL count results delivered to requesters 0 and 1.

Function
REQ-014 The block SHALL contain exactly one KS_16b instance (in0 = selected A, in1 = selected B, out0 = 17-bit sum), shared by both requesters.
REQ-015 The block SHALL be able to accept (can_accept = 1) when res_valid = 0, or when res_valid = 1 and res_ready = 1 in the same cycle.
REQ-016 When exactly one requester is valid, it SHALL be granted.
- When both are valid, the requester not named by the last-grant pointer SHALL be granted.
REQ-017 reqN_ready SHALL be combinational and equal grantN AND can_accept.
- The block SHALL never assert both ready signals in the same cycle.
- ready SHALL not depend on the same requester's valid through any loop other than arbitration.
REQ-018 A transfer on requester N (valid AND ready) in cycle t SHALL have these effects at t+1:
- res_valid = 1;
- res_sum = {carry, A+B};
- res_id = N;
- last-grant pointer = N.
REQ-019 Latency SHALL be exactly 1 cycle from acceptance to res_valid; throughput SHALL be one result per cycle while res_ready stays high.
REQ-020 When res_valid = 1 and res_ready = 0:
- res_sum and res_id SHALL hold stable;
- both ready signals SHALL be 0;
- the pointer SHALL not change.
REQ-021 When the result is drained with no new acceptance, res_valid SHALL return to 0 at t+1, and res_sum and res_id SHALL retain their last values.
REQ-022 cntN SHALL increment by 1 on each cycle where res_valid AND res_ready AND res_id = N.
- The count SHALL wrap from 0xFFFF to 0x0000.
REQ-023 Arithmetic SHALL be unsigned with no overflow loss: 0xFFFF + 0xFFFF SHALL give 0x1FFFE.
REQ-024 A simultaneous drain and acceptance SHALL deliver the old result and load the new one in the same edge, with no bubble.
REQ-025 Idle cycles (no valid) SHALL leave the pointer unchanged.

Reset
REQ-026 While rst = 1:
- res_valid = 0, res_sum = 0, res_id = 0, cnt0 = 0, cnt1 = 0;
- last-grant pointer = 1 - RR_INIT, so that RR_INIT wins the first contention;
- req0_ready and req1_ready SHALL be 0.
REQ-027 Reset asserted while a result is pending SHALL discard that result without counting it.

Verification
REQ-028 Bench SHALL cover the following directed scenarios:
- V1: Reset, then req0 = (0x1234, 0x0001) with res_ready = 1 -> req0_ready = 1; next cycle res_valid = 1, res_sum = 0x01235, res_id = 0; cnt0 = 1 one cycle later.
- V2: Both valid continuously, res_ready = 1, RR_INIT = 0 -> grants alternate 0,1,0,1; res_id sequence 0,1,0,1 with no idle cycles.
- V3: req1 = (0xFFFF, 0xFFFF) -> res_sum = 0x1FFFE, res_id = 1.
- V4: Result pending with res_ready = 0 for 3 cycles while both valid -> both ready = 0; res_sum stable; pointer unchanged; release -> next grant is the non-last requester.
- V5: rst pulsed while res_valid = 1 -> next cycle res_valid = 0, cnt0 = cnt1 = 0, res_sum = 0.
- V6: 65536 deliveries from req0 -> cnt0 wraps to 0x0000; cnt1 stays 0.
- V7: Randomized operands checked against a reference model computing in0 + in1 as 17 bits.
